// File: rtl/dmem_resp_model.sv
// dmem_resp_model: data-memory responder for the core's data bus.
// A three-state handshake (IDLE/WAIT/ACK) gives each request its own load or
// store latency. RAM is a big-endian byte array, and byte lanes wrap modulo
// 2^MEM_AW. Byte stores to STDOUT_ADDR go into a small FIFO with back-pressure.
// Stores to EXIT_ADDR set a sticky flag. max_addr tracks the highest RAM
// address that has been accessed.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   MREQ, WRITE       request valid, 1 = store / 0 = load
//   SIZE              00 word, 01 halfword, 1x byte
//   DAD, DDT_w        byte address, store data (right-justified)
//   DDT_r             load data, right-justified and zero-extended
//   ACKD_n            active-low acknowledge, one cycle per request
//   so_valid/so_data  STDOUT FIFO head; popped when so_valid && so_ready
//   so_ready          consumer ready
//   exit_flag         sticky program-exit indicator
//   max_addr          highest RAM address accepted since reset
module dmem_resp_model #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_AW      = 12,
    parameter int                    LOAD_LAT    = 1,
    parameter int                    STORE_LAT   = 1,
    parameter logic [ADDR_WIDTH-1:0] STDOUT_ADDR = 32'hf0000000,
    parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR   = 32'hff000000,
    parameter int                    FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MREQ,
    input  logic                  WRITE,
    input  logic [1:0]            SIZE,
    input  logic [ADDR_WIDTH-1:0] DAD,
    input  logic [DATA_WIDTH-1:0] DDT_w,
    output logic [DATA_WIDTH-1:0] DDT_r,
    output logic                  ACKD_n,
    output logic                  so_valid,
    output logic [7:0]            so_data,
    input  logic                  so_ready,
    output logic                  exit_flag,
    output logic [ADDR_WIDTH-1:0] max_addr
);

    localparam int FAW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    ackd_n_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    exit_q;
    logic [ADDR_WIDTH-1:0]   max_q;
    logic [FAW-1:0]          rd_ptr_q, wr_ptr_q;
    logic [FAW:0]            fcnt_q;

    // Captured request (data path, not reset)
    logic                    wr_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdat_q;

    logic [7:0]              mem [2**MEM_AW];
    logic [7:0]              fifo_mem [FIFO_DEPTH];

    logic                    is_so, is_exit, is_ram;
    logic                    req_ok, pop, push, fifo_full, stall, fire;
    logic [MEM_AW-1:0]       idx [4];
    logic [7:0]              wlane [4];
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign is_so     = (addr_q == STDOUT_ADDR);
    assign is_exit   = (addr_q == EXIT_ADDR);
    assign is_ram    = !is_so && !is_exit;
    assign req_ok    = MREQ && (WRITE == wr_q);
    assign fifo_full = (fcnt_q == (FAW+1)'(FIFO_DEPTH));
    assign pop       = (fcnt_q != '0) && so_ready;
    // A full FIFO only stalls when nothing is popped on this same edge
    assign stall     = wr_q && is_so && size_q[1] && fifo_full && !pop;
    // The edge that enters ACK; every side effect happens here and nowhere else
    assign fire      = !rst && (state_q == S_WAIT) && req_ok && (cnt_q == 4'd0) && !stall;
    assign push      = fire && wr_q && is_so && size_q[1];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = addr_q[MEM_AW-1:0] + MEM_AW'(k);
        end
    end

    // Store lanes: the most significant stored byte goes to the lowest address
    always_comb begin
        wlane[0] = 8'h00;
        wlane[1] = 8'h00;
        wlane[2] = 8'h00;
        wlane[3] = 8'h00;
        be       = 4'b0000;
        case (size_q)
            2'b00: begin
                wlane[0] = wdat_q[31:24];
                wlane[1] = wdat_q[23:16];
                wlane[2] = wdat_q[15:8];
                wlane[3] = wdat_q[7:0];
                be       = 4'b1111;
            end
            2'b01: begin
                wlane[0] = wdat_q[15:8];
                wlane[1] = wdat_q[7:0];
                be       = 4'b0011;
            end
            default: begin
                wlane[0] = wdat_q[7:0];
                be       = 4'b0001;
            end
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (is_ram) begin
            case (size_q)
                2'b00:   rd_word = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};
                2'b01:   rd_word = {16'h0000, mem[idx[0]], mem[idx[1]]};
                default: rd_word = {24'h000000, mem[idx[0]]};
            endcase
        end
    end

    // Request capture: any acceptance (from IDLE or ACK) latches the bus
    always_ff @(posedge clk) begin
        if (state_q != S_WAIT && MREQ) begin
            wr_q   <= WRITE;
            size_q <= SIZE;
            addr_q <= DAD;
            wdat_q <= DDT_w;
        end
    end

    always_ff @(posedge clk) begin
        if (fire && wr_q && is_ram) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx[k]] <= wlane[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= wdat_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            ackd_n_q <= 1'b1;
            rdata_q  <= '0;
            exit_q   <= 1'b0;
            max_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            ackd_n_q <= 1'b1;
            case (state_q)
                S_IDLE, S_ACK: begin
                    // ACK lasts one cycle; a held request is re-accepted right away
                    if (MREQ) begin
                        state_q <= S_WAIT;
                        cnt_q   <= WRITE ? 4'(STORE_LAT - 1) : 4'(LOAD_LAT - 1);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!req_ok) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!stall) begin
                        state_q  <= S_ACK;
                        ackd_n_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (fire && !wr_q) rdata_q <= rd_word;
            if (fire && wr_q && is_exit) exit_q <= 1'b1;
            if (fire && is_ram && (addr_q > max_q)) max_q <= addr_q;

            if (push) wr_ptr_q <= wr_ptr_q + FAW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FAW'(1);
            if (push && !pop)      fcnt_q <= fcnt_q + (FAW+1)'(1);
            else if (pop && !push) fcnt_q <= fcnt_q - (FAW+1)'(1);
        end
    end

    assign ACKD_n    = ackd_n_q;
    assign DDT_r     = rdata_q;
    assign exit_flag = exit_q;
    assign max_addr  = max_q;
    assign so_valid  = (fcnt_q != '0);
    assign so_data   = so_valid ? fifo_mem[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_dmem_resp_model.sv
module tb_dmem_resp_model;

    localparam logic [31:0] SO = 32'hf0000000;
    localparam logic [31:0] EX = 32'hff000000;
    localparam int LLAT = 4;
    localparam int SLAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MREQ = 1'b0, WRITE = 1'b0, so_ready = 1'b0;
    logic [1:0]  SIZE = 2'b00;
    logic [31:0] DAD = '0, DDT_w = '0;
    logic [31:0] DDT_r, max_addr;
    logic        ACKD_n, so_valid, exit_flag;
    logic [7:0]  so_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [7:0]  mm [4096];
    logic [7:0]  q [$];
    logic [31:0] max_m = '0;
    logic [31:0] rd_m  = '0;
    logic        exit_m = 1'b0;

    dmem_resp_model #(
        .LOAD_LAT (LLAT),
        .STORE_LAT(SLAT)
    ) dut (
        .clk(clk), .rst(rst), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
        .DAD(DAD), .DDT_w(DDT_w), .DDT_r(DDT_r), .ACKD_n(ACKD_n),
        .so_valid(so_valid), .so_data(so_data), .so_ready(so_ready),
        .exit_flag(exit_flag), .max_addr(max_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    endfunction

    // Apply the architectural effect of one acknowledged request
    task automatic model_ack(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        if (a == SO || a == EX) begin
            if (!w) rd_m = 32'h0;
            else if (a == EX) exit_m = 1'b1;
            else if (n == 1) q.push_back(d[7:0]);
        end else begin
            if (a > max_m) max_m = a;
            if (w) begin
                for (int k = 0; k < n; k++)
                    mm[(a + k) % 4096] = 8'((d >> (8 * (n - 1 - k))) & 32'hff);
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++)
                    v = (v << 8) | 32'(mm[(a + k) % 4096]);
                rd_m = v;
            end
        end
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        int  k;
        bit  got;
        MREQ = 1'b1; WRITE = w; SIZE = sz; DAD = a; DDT_w = d;
        @(posedge clk); #1;
        k = 0; got = 0;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (ACKD_n === 1'b0) got = 1;
        end
        MREQ = 1'b0;
        if (got) model_ack(w, sz, a, d);
        chk({tag, "_lat"}, 32'(k), w ? 32'(SLAT) : 32'(LLAT));
        if (!w) chk({tag, "_data"}, DDT_r, rd_m);
        chk({tag, "_max"}, max_addr, max_m);
        @(posedge clk); #1;
    endtask

    task automatic expect_no_ack(input string tag, input int cycles);
        bit seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (ACKD_n === 1'b0) seen = 1;
        end
        chk(tag, 32'(seen), 32'h0);
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 20) begin
            chk("drain_valid", 32'(so_valid), 32'h1);
            chk("drain_data", 32'(so_data), 32'(q[0]));
            so_ready = 1'b1;
            @(posedge clk); #1;
            so_ready = 1'b0;
            void'(q.pop_front());
            guard++;
        end
        chk("drain_empty", 32'(so_valid), 32'h0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0]  sz;
        logic        w;
        logic [31:0] max_save;
        int          sel;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ackd", 32'(ACKD_n), 32'h1);
        chk("rst_ddtr", DDT_r, 32'h0);
        chk("rst_exit", 32'(exit_flag), 32'h0);
        chk("rst_max", max_addr, 32'h0);
        chk("rst_sovalid", 32'(so_valid), 32'h0);
        chk("rst_sodata", 32'(so_data), 32'h0);

        // Fill the two regions used below so no load ever sees unwritten RAM
        for (int i = 0; i < 16; i++) do_req("init_lo", 1'b1, 2'b00, 32'(4 * i), $urandom);
        for (int i = 0; i < 16; i++) do_req("init_hi", 1'b1, 2'b00, 32'(12'hfc0 + 4 * i), $urandom);

        // Big-endian loads of all three sizes
        do_req("st_deadbeef", 1'b1, 2'b00, 32'h10, 32'hdeadbeef);
        do_req("ld_word", 1'b0, 2'b00, 32'h10, 32'h0);
        chk("ld_word_const", DDT_r, 32'hdeadbeef);
        do_req("ld_half", 1'b0, 2'b01, 32'h12, 32'h0);
        chk("ld_half_const", DDT_r, 32'h0000beef);
        do_req("ld_byte", 1'b0, 2'b10, 32'h11, 32'h0);
        chk("ld_byte_const", DDT_r, 32'h000000ad);

        // Byte store then word load of the same address
        do_req("st_byte5a", 1'b1, 2'b11, 32'h20, 32'h1234565a);
        do_req("ld_after5a", 1'b0, 2'b00, 32'h20, 32'h0);
        chk("ld_after5a_msb", {24'h0, DDT_r[31:24]}, 32'h5a);

        // Abort by dropping MREQ in the second cycle
        MREQ = 1'b1; WRITE = 1'b0; SIZE = 2'b00; DAD = 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        MREQ = 1'b0;
        expect_no_ack("abort_mreq_noack", 8);
        do_req("after_abort", 1'b0, 2'b00, 32'h10, 32'h0);

        // Abort by flipping WRITE: the store must leave RAM untouched
        MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'b10; DAD = 32'h30; DDT_w = 32'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        WRITE = 1'b0;
        @(posedge clk); #1;
        MREQ = 1'b0;
        expect_no_ack("abort_write_noack", 6);
        do_req("ld_abort_addr", 1'b0, 2'b10, 32'h30, 32'h0);

        // Word store wrapping past the top of RAM
        do_req("st_wrap", 1'b1, 2'b00, 32'hffe, 32'h11223344);
        chk("wrap_max_const", max_addr, 32'hffe);
        do_req("ld_wrap0", 1'b0, 2'b10, 32'hffe, 32'h0);
        chk("wrap_b0", DDT_r, 32'h11);
        do_req("ld_wrap1", 1'b0, 2'b10, 32'hfff, 32'h0);
        chk("wrap_b1", DDT_r, 32'h22);
        do_req("ld_wrap2", 1'b0, 2'b10, 32'h000, 32'h0);
        chk("wrap_b2", DDT_r, 32'h33);
        do_req("ld_wrap3", 1'b0, 2'b10, 32'h001, 32'h0);
        chk("wrap_b3", DDT_r, 32'h44);

        // STDOUT: fill the FIFO, then the ninth store must stall
        max_save = max_addr;
        for (int i = 0; i < 8; i++) do_req("so_fill", 1'b1, 2'b10, SO, 32'(8'h41 + i));
        MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'b10; DAD = SO; DDT_w = 32'h49;
        @(posedge clk); #1;
        expect_no_ack("so_stall", 8);
        chk("so_head_A", 32'(so_data), 32'h41);
        so_ready = 1'b1;
        @(posedge clk); #1;
        so_ready = 1'b0;
        MREQ = 1'b0;
        chk("so_unstall_ack", 32'(ACKD_n), 32'h0);
        void'(q.pop_front());
        model_ack(1'b1, 2'b10, SO, 32'h49);
        @(posedge clk); #1;
        drain();
        chk("so_max_unchanged", max_addr, max_save);
        do_req("ld_after_so", 1'b0, 2'b00, 32'h0, 32'h0);

        // EXIT port and special-address loads
        do_req("st_exit", 1'b1, 2'b00, EX, 32'h1);
        chk("exit_set", 32'(exit_flag), 32'h1);
        do_req("ld_exit", 1'b0, 2'b00, EX, 32'h0);
        do_req("ld_so", 1'b0, 2'b00, SO, 32'h0);
        do_req("st_so_word", 1'b1, 2'b00, SO, 32'h55);
        chk("so_word_discard", 32'(so_valid), 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 200; i++) begin
            w   = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            d   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)       a = ($urandom_range(0, 1) == 0) ? SO : EX;
            else if (sel < 5)   a = 32'($urandom_range(0, 32'h3c));
            else                a = 32'($urandom_range(32'hfc0, 32'hfff));
            if (a == SO && w && q.size() >= 8) w = 1'b0;
            do_req("rand", w, sz, a, d);
        end
        drain();
        chk("exit_sticky", 32'(exit_flag), 32'h1);

        // Reset in the middle of a store: request aborted, RAM kept
        MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'b00; DAD = 32'h8; DDT_w = 32'hcafef00d;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; MREQ = 1'b0;
        max_m = 32'h0; exit_m = 1'b0; q.delete();
        chk("rst2_exit", 32'(exit_flag), 32'h0);
        chk("rst2_ackd", 32'(ACKD_n), 32'h1);
        chk("rst2_max", max_addr, 32'h0);
        chk("rst2_sovalid", 32'(so_valid), 32'h0);
        chk("rst2_ddtr", DDT_r, 32'h0);
        @(posedge clk); #1;
        do_req("ld_after_rst", 1'b0, 2'b00, 32'h8, 32'h0);
        chk("exit_model", 32'(exit_flag), 32'(exit_m));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_resp_model.md
Name: dmem_resp_model

Overview:
- Synthesizable, parametrised data-memory responder for the core's data bus (MREQ/WRITE/SIZE/DAD/DDT/ACKD_n).
- Replaces the fixed single-latency bench memory.
- Adds:
  - independent programmable load and store latency
  - byte-addressed big-endian RAM with wrap-around
  - a back-pressured STDOUT byte FIFO
  - a sticky EXIT flag
  - a maximum-accessed-address tracker used for memory dumps
- Sits between the core's data port and either FPGA block RAM or the simulation top.

Parameters:
- DATA_WIDTH, 32, bus data width; fixed at 32, with byte lanes in big-endian order.
- ADDR_WIDTH, 32, width of DAD.
- MEM_AW, 12, log2 of RAM size in bytes; RAM index = address[MEM_AW-1:0].
- LOAD_LAT, 1, cycles from load acceptance to ACKD_n low; legal range 1..15.
- STORE_LAT, 1, cycles from store acceptance to ACKD_n low; legal range 1..15.
- STDOUT_ADDR, 32'hf0000000, address of the character-output port.
- EXIT_ADDR, 32'hff000000, address of the program-exit port.
- FIFO_DEPTH, 8, depth of the STDOUT FIFO; must be a power of 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- MREQ  in  1  data request valid.
- WRITE  in  1  1 = store, 0 = load.
- SIZE  in  2  00 = word, 01 = halfword, 10/11 = byte.
- DAD  in  ADDR_WIDTH  byte address.
- DDT_w  in  DATA_WIDTH  store data; halfword uses [15:0], byte uses [7:0].
- DDT_r  out  DATA_WIDTH  load data, right-justified and zero-extended.
- ACKD_n  out  1  active-low acknowledge, one cycle per request.
- so_valid  out  1  STDOUT FIFO not empty.
- so_data  out  8  STDOUT FIFO head byte.
- so_ready  in  1  consumer pops the head when so_valid&&so_ready.
- exit_flag  out  1  sticky, set by any store to EXIT_ADDR.
- max_addr  out  ADDR_WIDTH  highest RAM address accepted so far.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; ACKD_n=1; DDT_r=0; exit_flag=0; max_addr=0.
  - FIFO empty, so so_valid=0 and so_data=0.
  - RAM contents are not reset.
  - Reset mid-request aborts the request with no RAM write and no FIFO push.
- FSM IDLE:
  - MREQ=1 at an edge: capture {WRITE,SIZE,DAD,DDT_w}, load cnt = LOAD_LAT-1 or STORE_LAT-1, go to WAIT.
- FSM WAIT:
  - Each edge with MREQ=1 and WRITE equal to the captured value: if cnt!=0, decrement cnt; if cnt==0, go to ACK.
  - Each edge with MREQ=0, or WRITE differing from the captured value: abort to IDLE with no side effects; a new request is accepted only from IDLE.
- ACKD_n timing: low in exactly the cycle in which the state is ACK. For latency L, it is low during the L-th cycle after the acceptance edge.
- FSM ACK: lasts one cycle, then IDLE. A request still present is re-accepted at the following edge, so back-to-back requests have a period of L+1 cycles.
- Load data:
  - Registered on the edge that enters ACK; DDT_r holds that value until the next load's ACK.
  - word = {M[a],M[a+1],M[a+2],M[a+3]}; half = {16'b0,M[a],M[a+1]}; byte = {24'b0,M[a]}.
  - Byte indices wrap modulo 2^MEM_AW; alignment is not checked.
- Store data:
  - Committed on the edge that enters ACK, never earlier.
  - word writes M[a..a+3] = DDT_w[31:24..7:0]; half writes M[a],M[a+1] = DDT_w[15:8],[7:0]; byte writes M[a] = DDT_w[7:0].
  - Lanes wrap modulo 2^MEM_AW.
- STDOUT_ADDR:
  - Byte store pushes DDT_w[7:0] into the FIFO; RAM is unchanged.
  - If the FIFO is full while cnt==0, hold in WAIT until a pop frees a slot. A pop and a push in the same edge is legal when full.
  - Word or halfword store is acknowledged and discarded.
  - Load returns 0.
- EXIT_ADDR:
  - Store sets exit_flag at the ACK edge and is acknowledged; RAM is unchanged.
  - Load returns 0.
  - exit_flag clears only on rst.
- max_addr:
  - Updated at the ACK edge of any load or store whose DAD is neither STDOUT_ADDR nor EXIT_ADDR: max_addr = max(max_addr, DAD).
  - Comparison is unsigned, on the full ADDR_WIDTH.
- FIFO behaviour:
  - Pop when empty has no effect.
  - Push when full is impossible because of the stall.
  - Pointers wrap at FIFO_DEPTH.
  - Order is strictly FIFO.

Test Plan:
- LOAD_LAT=1: preload M[0x10..0x13]=de ad be ef; word load @0x10 → ACKD_n low 1 cycle after acceptance, DDT_r=32'hdeadbeef; half @0x12 → 32'h0000beef; byte @0x11 → 32'h000000ad.
- STORE_LAT=3: byte store 0x5a @0x20, then word load @0x20 → ACKD_n low in the 3rd cycle after the store's acceptance; M[0x20..0x23]=5a ?? ?? ??; the load returns 32'h5a??????; M[0x20] is unchanged before the ACK edge.
- LOAD_LAT=4: drop MREQ in cycle 2 → no ACK, back to IDLE; reassert MREQ → ACK 4 cycles after the new acceptance. Also flip WRITE mid-WAIT → abort, no RAM write.
- MEM_AW=12: word store 32'h11223344 @0xFFE → M[0xFFE]=11, M[0xFFF]=22, M[0x000]=33, M[0x001]=44; max_addr=0xFFE.
- FIFO_DEPTH=8 with so_ready=0: send 9 byte stores to STDOUT_ADDR ('A'..'I') → 8 ACKs, 9th held in WAIT; pulse so_ready for one cycle → 9th ACKs; drain yields A..I in order; RAM and max_addr unchanged.
- Store @EXIT_ADDR → exit_flag=1 at the ACK edge and stays 1 through later requests; assert rst for one edge → exit_flag=0, ACKD_n=1, max_addr=0, so_valid=0.
